// File: rtl/ps2_data_in_receiver_if.sv
// ps2_data_in_receiver_if
//   Groups the receive-side PS/2 signals and the consumer valid/ack handshake.
//   slave  : the receiver (samples line strobes and ack, drives byte/status).
//   master : the environment (drives line strobes, enable and ack).
//   Signals:
//     rx_enable        high = reception allowed, low = transmitter owns the bus
//     ps2_clk_negedge  one-clk strobe, synchronized PS/2 clock falling edge
//     ps2_data         synchronized PS/2 data level
//     data_ack         consumer accepts the held byte
//     rx_data          last accepted byte
//     data_valid       rx_data holds an unconsumed byte
//     rx_busy          frame in progress
//     parity_error / framing_error / timeout_error / overrun_error  one-clk pulses
interface ps2_data_in_receiver_if;
    logic       rx_enable;
    logic       ps2_clk_negedge;
    logic       ps2_data;
    logic       data_ack;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       rx_busy;
    logic       parity_error;
    logic       framing_error;
    logic       timeout_error;
    logic       overrun_error;

    modport slave (
        input  rx_enable,
        input  ps2_clk_negedge,
        input  ps2_data,
        input  data_ack,
        output rx_data,
        output data_valid,
        output rx_busy,
        output parity_error,
        output framing_error,
        output timeout_error,
        output overrun_error
    );

    modport master (
        output rx_enable,
        output ps2_clk_negedge,
        output ps2_data,
        output data_ack,
        input  rx_data,
        input  data_valid,
        input  rx_busy,
        input  parity_error,
        input  framing_error,
        input  timeout_error,
        input  overrun_error
    );
endinterface

// File: rtl/ps2_data_in_receiver.sv
// ps2_data_in_receiver
//   Receives device-to-host PS/2 frames (start, 8 data bits LSB first, odd parity,
//   stop) and holds each good byte in a single-entry valid/ack register. Reports
//   parity, framing, inter-bit timeout and overrun errors as one-clk pulses.
//   Dropping rx_enable aborts any frame in progress without an error.
//   Ports:
//     clk     system clock
//     reset   synchronous, active-high
//     rx_bus  ps2_data_in_receiver_if.slave (line strobes, handshake, status)
//   All outputs come straight from flops.
module ps2_data_in_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TIMEOUT_WIDTH  = 17
) (
    input logic                      clk,
    input logic                      reset,
    ps2_data_in_receiver_if.slave    rx_bus
);

    localparam logic [TIMEOUT_WIDTH-1:0] TmoLimit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StCommit
    } state_e;

    state_e                   state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic                     stop_q, stop_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_inc;
    logic [7:0]               rx_data_q, rx_data_d;
    logic                     valid_q, valid_d;
    logic                     busy_q;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     terr_q, terr_d;
    logic                     oerr_q, oerr_d;
    logic                     commit_good;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        stop_d      = stop_q;
        tmo_cnt_d   = '0;
        tmo_inc     = (tmo_cnt_q == TmoLimit) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        rx_data_d   = rx_data_q;
        valid_d     = valid_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        terr_d      = 1'b0;
        oerr_d      = 1'b0;
        commit_good = 1'b0;

        if (!rx_bus.rx_enable && (state_q != StIdle)) begin
            // Transmitter has taken the bus: drop the partial frame silently.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_bus.rx_enable && rx_bus.ps2_clk_negedge && !rx_bus.ps2_data) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    if (rx_bus.ps2_clk_negedge) begin
                        shift_d   = {rx_bus.ps2_data, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StParity;
                        end
                    end
                end
                StParity: begin
                    if (rx_bus.ps2_clk_negedge) begin
                        parity_d = rx_bus.ps2_data;
                        state_d  = StStop;
                    end
                end
                StStop: begin
                    if (rx_bus.ps2_clk_negedge) begin
                        stop_d  = rx_bus.ps2_data;
                        state_d = StCommit;
                    end
                end
                StCommit: begin
                    state_d = StIdle;
                    if (!stop_q) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, parity_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        commit_good = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Inter-bit watchdog; a negedge in the same cycle wins over expiry.
            if ((state_q == StData) || (state_q == StParity) || (state_q == StStop)) begin
                if (!rx_bus.ps2_clk_negedge) begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TmoLimit) begin
                        terr_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
        end

        // Holding register: a same-cycle ack frees the slot for the new byte.
        if (commit_good) begin
            if (!valid_q || rx_bus.data_ack) begin
                rx_data_d = shift_q;
                valid_d   = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end else if (rx_bus.data_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            stop_q    <= 1'b0;
            tmo_cnt_q <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            stop_q    <= stop_d;
            tmo_cnt_q <= tmo_cnt_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d != StIdle);
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
            oerr_q    <= oerr_d;
        end
    end

    assign rx_bus.rx_data       = rx_data_q;
    assign rx_bus.data_valid    = valid_q;
    assign rx_bus.rx_busy       = busy_q;
    assign rx_bus.parity_error  = perr_q;
    assign rx_bus.framing_error = ferr_q;
    assign rx_bus.timeout_error = terr_q;
    assign rx_bus.overrun_error = oerr_q;

endmodule

// File: tb/tb_ps2_data_in_receiver.sv
// Bench for ps2_data_in_receiver: drives PS/2 frames as negedge strobes, predicts
// each commit result into a scoreboard queue and compares when the result appears.
module tb_ps2_data_in_receiver;

    localparam int unsigned Tmo = 200;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
        logic       oerr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic       mv;
    logic [7:0] md;

    ps2_data_in_receiver_if rx_bus ();

    ps2_data_in_receiver #(
        .TIMEOUT_CYCLES(Tmo),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_bus(rx_bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One falling edge with the given data level; returns in the following cycle.
    task automatic strobe(input logic b);
        rx_bus.ps2_data        = b;
        rx_bus.ps2_clk_negedge = 1'b1;
        tick();
        rx_bus.ps2_clk_negedge = 1'b0;
        rx_bus.ps2_data        = 1'b1;
    endtask

    // Drives a whole frame and predicts the commit outcome. Returns in the COMMIT
    // cycle with data_ack set to ack_commit for that cycle.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic ack_commit);
        exp_t e;
        e.perr = 1'b0;
        e.ferr = 1'b0;
        e.oerr = 1'b0;
        if (!stp) begin
            e.ferr = 1'b1;
            if (ack_commit) mv = 1'b0;
        end else if ((^d) == par) begin
            e.perr = 1'b1;
            if (ack_commit) mv = 1'b0;
        end else if (!mv || ack_commit) begin
            mv = 1'b1;
            md = d;
        end else begin
            e.oerr = 1'b1;
        end
        e.data  = md;
        e.valid = mv;
        sb.push_back(e);
        strobe(1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            strobe(d[i]);
            tick();
        end
        strobe(par);
        tick();
        strobe(stp);
        rx_bus.data_ack = ack_commit;
    endtask

    task automatic check_commit(input string name);
        exp_t e;
        if (rx_bus.rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_in_commit: got %0b want 1", name, rx_bus.rx_busy);
        end
        total++;
        tick();
        rx_bus.data_ack = 1'b0;
        if (sb.size() == 0) begin
            bad++;
            total++;
            $display("FAIL %s scoreboard: got empty queue want one entry", name);
            return;
        end
        e = sb.pop_front();
        if (rx_bus.rx_data !== e.data) begin
            bad++;
            $display("FAIL %s rx_data: got %h want %h", name, rx_bus.rx_data, e.data);
        end
        total++;
        if (rx_bus.data_valid !== e.valid) begin
            bad++;
            $display("FAIL %s data_valid: got %0b want %0b", name, rx_bus.data_valid, e.valid);
        end
        total++;
        if ({rx_bus.parity_error, rx_bus.framing_error, rx_bus.overrun_error,
             rx_bus.timeout_error, rx_bus.rx_busy} !== {e.perr, e.ferr, e.oerr, 2'b00}) begin
            bad++;
            $display("FAIL %s pulses(p,f,o,t,busy): got %b%b%b%b%b want %b%b%b00", name,
                     rx_bus.parity_error, rx_bus.framing_error, rx_bus.overrun_error,
                     rx_bus.timeout_error, rx_bus.rx_busy, e.perr, e.ferr, e.oerr);
        end
        total++;
        tick();
        if ({rx_bus.parity_error, rx_bus.framing_error, rx_bus.overrun_error,
             rx_bus.timeout_error} !== 4'b0000) begin
            bad++;
            $display("FAIL %s pulse_width: got %b%b%b%b want 0000", name,
                     rx_bus.parity_error, rx_bus.framing_error, rx_bus.overrun_error,
                     rx_bus.timeout_error);
        end
        total++;
    endtask

    task automatic do_ack(input string name);
        rx_bus.data_ack = 1'b1;
        tick();
        rx_bus.data_ack = 1'b0;
        mv = 1'b0;
        if (rx_bus.data_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s ack_clear: got %0b want 0", name, rx_bus.data_valid);
        end
        total++;
    endtask

    task automatic test_reset();
        reset                  = 1'b1;
        rx_bus.rx_enable       = 1'b1;
        rx_bus.ps2_clk_negedge = 1'b0;
        rx_bus.ps2_data        = 1'b1;
        rx_bus.data_ack        = 1'b0;
        mv                     = 1'b0;
        md                     = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        if ({rx_bus.rx_data, rx_bus.data_valid, rx_bus.rx_busy, rx_bus.parity_error,
             rx_bus.framing_error, rx_bus.timeout_error, rx_bus.overrun_error} !== 14'h0) begin
            bad++;
            $display("FAIL reset_state: got %h/%b%b%b%b%b%b want 00/000000", rx_bus.rx_data,
                     rx_bus.data_valid, rx_bus.rx_busy, rx_bus.parity_error,
                     rx_bus.framing_error, rx_bus.timeout_error, rx_bus.overrun_error);
        end
        total++;
    endtask

    task automatic test_good_frame();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        check_commit("good_5a");
        repeat (3) tick();
        if (rx_bus.data_valid !== 1'b1) begin
            bad++;
            $display("FAIL good_5a hold: got %0b want 1", rx_bus.data_valid);
        end
        total++;
        do_ack("good_5a");
    endtask

    task automatic test_errors();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_commit("parity_bad");
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        check_commit("framing_bad");
    endtask

    task automatic test_timeout();
        int k;
        strobe(1'b0);
        tick();
        strobe(1'b1);
        tick();
        strobe(1'b0);
        tick();
        strobe(1'b1);
        // k counts cycles after the last negedge cycle; the counter reaches the
        // limit Tmo cycles later and the registered pulse shows one cycle after.
        k = 1;
        while (!rx_bus.timeout_error && k < 400) begin
            if (rx_bus.rx_busy !== 1'b1) break;
            tick();
            k++;
        end
        if (k !== Tmo + 1) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want %0d", k, Tmo + 1);
        end
        total++;
        if ({rx_bus.timeout_error, rx_bus.rx_busy, rx_bus.data_valid} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_state(t,busy,valid): got %b%b%b want 100",
                     rx_bus.timeout_error, rx_bus.rx_busy, rx_bus.data_valid);
        end
        total++;
        tick();
        if (rx_bus.timeout_error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_width: got %0b want 0", rx_bus.timeout_error);
        end
        total++;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check_commit("after_timeout_a5");
        do_ack("after_timeout_a5");
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        check_commit("ovr_first_11");
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        check_commit("ovr_drop_22");
        do_ack("ovr_drop_22");
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        check_commit("ovr_again_11");
        send_frame(8'h22, 1'b1, 1'b1, 1'b1);
        check_commit("ovr_ack_22");
        do_ack("ovr_ack_22");
    endtask

    task automatic test_abort();
        strobe(1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            strobe(i[0]);
            tick();
        end
        rx_bus.rx_enable = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            if ({rx_bus.rx_busy, rx_bus.parity_error, rx_bus.framing_error,
                 rx_bus.timeout_error, rx_bus.overrun_error, rx_bus.data_valid} !== 6'b0) begin
                bad++;
                $display("FAIL abort_quiet[%0d]: got %b%b%b%b%b%b want 000000", i,
                         rx_bus.rx_busy, rx_bus.parity_error, rx_bus.framing_error,
                         rx_bus.timeout_error, rx_bus.overrun_error, rx_bus.data_valid);
            end
            total++;
            tick();
        end
        rx_bus.rx_enable = 1'b1;
        tick();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        check_commit("after_abort_3c");
    endtask

    task automatic test_reset_mid();
        strobe(1'b0);
        tick();
        strobe(1'b1);
        tick();
        strobe(1'b0);
        reset = 1'b1;
        tick();
        if ({rx_bus.rx_data, rx_bus.data_valid, rx_bus.rx_busy, rx_bus.parity_error,
             rx_bus.framing_error, rx_bus.timeout_error, rx_bus.overrun_error} !== 14'h0) begin
            bad++;
            $display("FAIL reset_mid: got %h/%b%b%b%b%b%b want 00/000000", rx_bus.rx_data,
                     rx_bus.data_valid, rx_bus.rx_busy, rx_bus.parity_error,
                     rx_bus.framing_error, rx_bus.timeout_error, rx_bus.overrun_error);
        end
        total++;
        reset = 1'b0;
        mv    = 1'b0;
        md    = 8'h00;
        tick();
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        check_commit("after_reset_ff");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_timeout();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_data_in_receiver.md
# ps2_data_in_receiver

Receives device-to-host PS/2 frames (start, 8 data bits LSB first, odd parity, stop) and presents each good byte through a single-entry valid/ack holding register. It is the receive-direction partner to the PS/2 command transmitter and shares the same pre-synchronized clock-edge strobes. It detects parity, framing, inter-bit timeout and overrun conditions. It also yields the bus, aborting any frame in progress, while the transmitter owns the lines.

## Interface
- TIMEOUT_CYCLES, 100000: clk cycles allowed between consecutive PS/2 falling edges inside a frame (2 ms at 50 MHz).
- TIMEOUT_WIDTH, 17: width of the timeout counter; must hold TIMEOUT_CYCLES.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_enable  in  1  high = reception allowed; low = idle/abort (transmitter owns bus).
- ps2_clk_negedge  in  1  one-clk strobe, synchronized PS/2 clock falling edge.
- ps2_data  in  1  synchronized PS/2 data line level.
- data_ack  in  1  consumer accepts the held byte.
- rx_data  out  8  last accepted byte.
- data_valid  out  1  rx_data holds an unconsumed byte.
- rx_busy  out  1  frame in progress (state not IDLE).
- parity_error  out  1  one-clk pulse, bad parity.
- framing_error  out  1  one-clk pulse, stop bit sampled 0.
- timeout_error  out  1  one-clk pulse, inter-bit timeout.
- overrun_error  out  1  one-clk pulse, good byte dropped because data_valid was high.

## Operation
- States:
  - IDLE: on negedge with rx_enable=1 and ps2_data=0 (start bit), go to DATA, clear bit_count and the timeout counter. A negedge with ps2_data=1 is ignored.
  - DATA: each negedge shifts the byte register right with ps2_data entering bit 7, so bits arrive LSB first. bit_count increments 0..7. The negedge that captures bit 7 goes to PARITY.
  - PARITY: the next negedge captures the parity bit and goes to STOP.
  - STOP: the next negedge captures the stop bit and goes to COMMIT.
  - COMMIT: one cycle, then IDLE unconditionally.
- COMMIT evaluation, in priority order:
  - stop=0: framing_error pulses; the byte is discarded.
  - else parity wrong, i.e. XOR of the 8 data bits and the parity bit = 0: parity_error pulses; the byte is discarded.
  - else the byte is good:
    - If data_valid=0, or data_ack=1 in this same cycle: load rx_data and set data_valid=1.
    - Else: rx_data is kept, overrun_error pulses, and the new byte is dropped.
- data_ack while data_valid=1 and no simultaneous good commit: data_valid clears next cycle. data_ack while data_valid=0 is ignored.
- Timeout counter:
  - Runs in DATA, PARITY and STOP. Clears on every negedge and outside those states. Saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES: timeout_error pulses and the state goes to IDLE. A negedge in that same cycle takes priority.
- rx_enable=0 in any non-IDLE state: abort to IDLE next cycle. No error pulse; the partial byte is discarded; data_valid and rx_data are untouched.
- reset: state IDLE; all outputs 0; rx_data=8'h00; internal counters and shift register cleared. Applies mid-frame as well.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Stop-bit negedge sampled in cycle N → COMMIT in cycle N+1 → data_valid, rx_data and error pulses visible in cycle N+2.
- Error pulses are exactly one clk wide. At most one of parity/framing/overrun per frame.
- rx_busy is high from the cycle after the start-bit negedge through the COMMIT cycle inclusive.
- data_valid stays high indefinitely until acked. Ack-to-clear latency is 1 cycle.

## Test plan
- Good frame 0x5A: bits start 0, data 0,1,0,1,1,0,1,0 LSB first, parity 1, stop 1 → rx_data=0x5A, data_valid=1 at N+2, no errors. Then data_ack → data_valid=0 next cycle.
- Frame 0x5A with parity 0 → parity_error single pulse, data_valid stays 0. Frame 0x00 with parity 1 and stop 0 → framing_error pulse only.
- TIMEOUT_CYCLES=200: start bit plus 3 data bits, then no edges → timeout_error pulses exactly 200 cycles after the last negedge, rx_busy falls, data_valid stays 0. A following good 0xA5 frame → received correctly.
- Receive 0x11 without ack, then good 0x22 → overrun_error pulse, rx_data remains 0x11. Repeat with data_ack asserted in the 0x22 COMMIT cycle → rx_data=0x22, data_valid stays 1, no overrun.
- rx_enable dropped after 5 data bits → IDLE next cycle, no pulses. Re-enabled, then good 0x3C → rx_data=0x3C.
- reset asserted mid-DATA with data_valid=1 → all outputs 0 the next cycle. The next full frame 0xFF (parity 1) → received normally.
